// File: rtl/prefetch88_pkg.sv
// rtl/prefetch88_pkg.sv - shared declarations for the 8088 prefetch queue
package prefetch88_pkg;

  localparam logic [15:0] DEF_RESET_CS = 16'hF000;
  localparam logic [15:0] DEF_RESET_IP = 16'h0000;

  // Real-mode linear address: seg*16 + off, truncated to the 20-bit bus
  function automatic logic [19:0] linear_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH x 8 byte queue with push/pop/clear, show-ahead head
module prefetch_fifo
  import prefetch88_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Pointer and occupancy bookkeeping; clear has priority over push/pop
  always_ff @(posedge clock) begin
    if (enable) begin
      if (reset || clear) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Byte storage is deliberately left unreset; only the pointers define validity
  always_ff @(posedge clock) begin
    if (enable && push && !reset && !clear) begin
      mem[wptr] <= wdata;
    end
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/prefetch88.sv
// rtl/prefetch88.sv - instruction prefetch queue feeding the opcode/modrm decoder
module prefetch88
  import prefetch88_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_CS = DEF_RESET_CS,
  parameter logic [15:0] RESET_IP = DEF_RESET_IP
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     locked,
  input  logic                     bus_busy,
  output logic [19:0]              fetch_addr,
  input  logic [7:0]               bus,
  output logic                     q_valid,
  output logic [7:0]               q_byte,
  output logic [15:0]              q_ip,
  input  logic                     q_pop,
  output logic [$clog2(DEPTH):0]   q_count,
  input  logic                     flush,
  input  logic [15:0]              flush_cs,
  input  logic [15:0]              flush_ip
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   fcs;
  logic [15:0]   fip;
  logic [15:0]   hip;
  logic [CW-1:0] count;
  logic          push_eff;
  logic          pop_eff;

  // Fetch only into free space (no same-cycle pop lookahead); pop only a held byte
  always_comb begin
    push_eff = !bus_busy && (count < CW'(DEPTH));
    pop_eff  = q_pop && (count != '0);
  end

  // Fetch segment/offset and head offset; flush redirects and realigns both offsets
  always_ff @(posedge clock) begin
    if (locked) begin
      if (reset) begin
        fcs <= RESET_CS;
        fip <= RESET_IP;
        hip <= RESET_IP;
      end else if (flush) begin
        fcs <= flush_cs;
        fip <= flush_ip;
        hip <= flush_ip;
      end else begin
        if (push_eff) fip <= fip + 16'd1;
        if (pop_eff)  hip <= hip + 16'd1;
      end
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .enable(locked),
    .clear (flush),
    .push  (push_eff),
    .pop   (pop_eff),
    .wdata (bus),
    .rdata (q_byte),
    .count (count)
  );

  assign fetch_addr = linear_addr(fcs, fip);
  assign q_valid    = (count != '0);
  assign q_ip       = hip;
  assign q_count    = count;

  // Bytes between head and fetch pointer are exactly the queued bytes
  a_offset_gap : assert property (@(posedge clock) disable iff (reset)
    (fip - hip) == 16'(count));

endmodule
